// File: rtl/axi_rd_pkg.sv
`default_nettype none
// axi_rd_pkg: shared sizing, AR FSM state type and AXI response codes for the read arbiter.
// Revision: 1.0
package axi_rd_pkg;

  localparam int NUM_REQ = 4;
  localparam int IDX_W   = 2;
  localparam int ID_W    = 8;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    HOLD = 1'b1
  } ar_state_e;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

endpackage
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// rr_arbiter: combinational round-robin pick of the first eligible requester at or after rr_ptr.
// Revision: 1.0
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = 2
) (
  input  logic [NUM_REQ-1:0] eligible,
  input  logic [IDX_W-1:0]   rr_ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   win_idx
);

  localparam logic [IDX_W:0] NREQ = (IDX_W+1)'(NUM_REQ);

  logic [IDX_W:0] cand;
  logic           found;

  always_comb begin
    grant   = '0;
    win_idx = '0;
    cand    = '0;
    found   = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      // Candidate index is rr_ptr + k folded back into 0..NUM_REQ-1.
      cand = {1'b0, rr_ptr} + (IDX_W+1)'(k);
      if (cand >= NREQ) begin
        cand = cand - NREQ;
      end
      if (!found && eligible[cand[IDX_W-1:0]]) begin
        found                    = 1'b1;
        grant[cand[IDX_W-1:0]]   = 1'b1;
        win_idx                  = cand[IDX_W-1:0];
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/axi_rd_arb.sv
`default_nettype none
// axi_rd_arb: round-robin share of one AXI read port among NUM_REQ requesters, ID-tagged R routing.
// Revision: 1.0
module axi_rd_arb #(
  parameter int NUM_REQ    = axi_rd_pkg::NUM_REQ,
  parameter int IDX_W      = axi_rd_pkg::IDX_W,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 64,
  parameter int MAX_OUTST  = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            up_arvld,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] up_araddr,
  input  logic [NUM_REQ*8-1:0]          up_arlen,
  input  logic [NUM_REQ*3-1:0]          up_arsize,
  input  logic [NUM_REQ*2-1:0]          up_arburst,
  output logic [NUM_REQ-1:0]            up_arrdy,
  output logic [NUM_REQ-1:0]            up_rvld,
  output logic [DATA_WIDTH-1:0]         up_rdata,
  output logic [1:0]                    up_rresp,
  output logic                          up_rlast,
  input  logic [NUM_REQ-1:0]            up_rrdy,
  output logic                          dn_arvld,
  input  logic                          dn_arrdy,
  output logic [7:0]                    dn_arid,
  output logic [ADDR_WIDTH-1:0]         dn_araddr,
  output logic [7:0]                    dn_arlen,
  output logic [2:0]                    dn_arsize,
  output logic [1:0]                    dn_arburst,
  input  logic                          dn_rvld,
  input  logic [7:0]                    dn_rid,
  input  logic [DATA_WIDTH-1:0]         dn_rdata,
  input  logic [1:0]                    dn_rresp,
  input  logic                          dn_rlast,
  output logic                          dn_rrdy,
  output logic                          err_stray
);

  import axi_rd_pkg::*;

  localparam int               CNT_W    = 3;
  localparam logic [CNT_W-1:0] MAX_CNT  = CNT_W'(MAX_OUTST);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REQ - 1);

  ar_state_e              state;
  ar_state_e              state_nxt;
  logic [IDX_W-1:0]       rr_ptr;
  logic [CNT_W-1:0]       outst [NUM_REQ];

  logic [IDX_W-1:0]       hold_idx;
  logic [ADDR_WIDTH-1:0]  hold_addr;
  logic [7:0]             hold_len;
  logic [2:0]             hold_size;
  logic [1:0]             hold_burst;

  logic [NUM_REQ-1:0]     eligible;
  logic [NUM_REQ-1:0]     grant;
  logic [IDX_W-1:0]       win_idx;
  logic                   capture;

  logic [ADDR_WIDTH-1:0]  sel_addr;
  logic [7:0]             sel_len;
  logic [2:0]             sel_size;
  logic [1:0]             sel_burst;

  logic [IDX_W-1:0]       rid_idx;
  logic                   rid_hi_nz;
  logic                   idx_hit;
  logic [CNT_W-1:0]       idx_cnt;
  logic                   rrdy_sel;
  logic                   stray;
  logic                   r_done_last;
  logic [NUM_REQ-1:0]     inc;
  logic [NUM_REQ-1:0]     dec;

  // ---------------- AR arbitration ----------------
  generate
    for (genvar i = 0; i < NUM_REQ; i++) begin : g_elig
      assign eligible[i] = up_arvld[i] && (outst[i] < MAX_CNT);
      assign inc[i]      = capture && grant[i];
      assign dec[i]      = r_done_last && (rid_idx == IDX_W'(i));
      assign up_rvld[i]  = dn_rvld && !stray && (rid_idx == IDX_W'(i));
    end
  endgenerate

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr_arbiter (
    .eligible (eligible),
    .rr_ptr   (rr_ptr),
    .grant    (grant),
    .win_idx  (win_idx)
  );

  // Reset overrides the combinational accept so nothing is granted while rst is high.
  assign capture  = !rst && ((state == IDLE) || dn_arrdy) && (|eligible);
  assign up_arrdy = capture ? grant : '0;

  always_comb begin
    sel_addr  = '0;
    sel_len   = '0;
    sel_size  = '0;
    sel_burst = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        sel_addr  = up_araddr[i*ADDR_WIDTH +: ADDR_WIDTH];
        sel_len   = up_arlen[i*8 +: 8];
        sel_size  = up_arsize[i*3 +: 3];
        sel_burst = up_arburst[i*2 +: 2];
      end
    end
  end

  always_comb begin
    state_nxt = state;
    if (capture) begin
      state_nxt = HOLD;
    end else if ((state == HOLD) && dn_arrdy) begin
      state_nxt = IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr     <= '0;
      hold_idx   <= '0;
      hold_addr  <= '0;
      hold_len   <= '0;
      hold_size  <= '0;
      hold_burst <= '0;
    end else if (capture) begin
      rr_ptr     <= (win_idx == LAST_IDX) ? '0 : win_idx + 1'b1;
      hold_idx   <= win_idx;
      hold_addr  <= sel_addr;
      hold_len   <= sel_len;
      hold_size  <= sel_size;
      hold_burst <= sel_burst;
    end
  end

  assign dn_arvld   = (state == HOLD);
  assign dn_arid    = ID_W'(hold_idx);
  assign dn_araddr  = hold_addr;
  assign dn_arlen   = hold_len;
  assign dn_arsize  = hold_size;
  assign dn_arburst = hold_burst;

  // ---------------- R routing ----------------
  assign rid_idx   = dn_rid[IDX_W-1:0];
  assign rid_hi_nz = |dn_rid[ID_W-1:IDX_W];

  always_comb begin
    idx_hit  = 1'b0;
    idx_cnt  = '0;
    rrdy_sel = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (rid_idx == IDX_W'(i)) begin
        idx_hit  = 1'b1;
        idx_cnt  = outst[i];
        rrdy_sel = up_rrdy[i];
      end
    end
  end

  // A beat nobody is waiting for is sunk here so it cannot wedge the shared R channel.
  assign stray       = !idx_hit || rid_hi_nz || (idx_cnt == '0);
  assign dn_rrdy     = stray || rrdy_sel;
  assign r_done_last = dn_rvld && dn_rrdy && dn_rlast && !stray;

  assign up_rdata = dn_rdata;
  assign up_rresp = dn_rresp;
  assign up_rlast = dn_rlast;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        outst[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (inc[i] && !dec[i]) begin
          outst[i] <= outst[i] + 1'b1;
        end else if (dec[i] && !inc[i]) begin
          outst[i] <= outst[i] - 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      err_stray <= 1'b0;
    end else if (dn_rvld && stray) begin
      err_stray <= 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_axi_rd_arb.sv
`default_nettype none
// tb_axi_rd_arb: directed scenarios plus a randomized run against a transaction-level reference model.
// Revision: 1.0
module tb_axi_rd_arb;

  localparam int NR = 4;
  localparam int AW = 32;
  localparam int DW = 64;
  localparam int MO = 4;

  logic           clk = 1'b0;
  logic           rst;
  logic [NR-1:0]  up_arvld;
  logic [NR*AW-1:0] up_araddr;
  logic [NR*8-1:0]  up_arlen;
  logic [NR*3-1:0]  up_arsize;
  logic [NR*2-1:0]  up_arburst;
  logic [NR-1:0]  up_arrdy;
  logic [NR-1:0]  up_rvld;
  logic [DW-1:0]  up_rdata;
  logic [1:0]     up_rresp;
  logic           up_rlast;
  logic [NR-1:0]  up_rrdy;
  logic           dn_arvld;
  logic           dn_arrdy;
  logic [7:0]     dn_arid;
  logic [AW-1:0]  dn_araddr;
  logic [7:0]     dn_arlen;
  logic [2:0]     dn_arsize;
  logic [1:0]     dn_arburst;
  logic           dn_rvld;
  logic [7:0]     dn_rid;
  logic [DW-1:0]  dn_rdata;
  logic [1:0]     dn_rresp;
  logic           dn_rlast;
  logic           dn_rrdy;
  logic           err_stray;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  axi_rd_arb #(
    .NUM_REQ(NR), .IDX_W(2), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_OUTST(MO)
  ) dut (
    .clk(clk), .rst(rst),
    .up_arvld(up_arvld), .up_araddr(up_araddr), .up_arlen(up_arlen),
    .up_arsize(up_arsize), .up_arburst(up_arburst), .up_arrdy(up_arrdy),
    .up_rvld(up_rvld), .up_rdata(up_rdata), .up_rresp(up_rresp),
    .up_rlast(up_rlast), .up_rrdy(up_rrdy),
    .dn_arvld(dn_arvld), .dn_arrdy(dn_arrdy), .dn_arid(dn_arid),
    .dn_araddr(dn_araddr), .dn_arlen(dn_arlen), .dn_arsize(dn_arsize),
    .dn_arburst(dn_arburst), .dn_rvld(dn_rvld), .dn_rid(dn_rid),
    .dn_rdata(dn_rdata), .dn_rresp(dn_rresp), .dn_rlast(dn_rlast),
    .dn_rrdy(dn_rrdy), .err_stray(err_stray)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    up_arvld = '0; up_araddr = '0; up_arlen = '0; up_arsize = '0; up_arburst = '0;
    up_rrdy = '0; dn_arrdy = 1'b0; dn_rvld = 1'b0; dn_rid = '0; dn_rdata = '0;
    dn_rresp = '0; dn_rlast = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle_inputs();
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic set_req(input int i, input logic [AW-1:0] a, input logic [7:0] l);
    up_araddr[i*AW +: AW] = a;
    up_arlen[i*8 +: 8]    = l;
    up_arsize[i*3 +: 3]   = 3'd3;
    up_arburst[i*2 +: 2]  = 2'b01;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle_inputs();
    for (int i = 0; i < NR; i++) set_req(i, 32'hA000 + i, 8'd7);
    up_arvld = 4'b1111;
    dn_arrdy = 1'b1;
    tick();
    tick();
    #1;
    n_cmp++; if (dn_arvld !== 1'b0) begin n_fail++; $display("FAIL reset_arvld got=%b exp=0", dn_arvld); end
    n_cmp++; if (err_stray !== 1'b0) begin n_fail++; $display("FAIL reset_err got=%b exp=0", err_stray); end
    n_cmp++; if (up_arrdy !== 4'b0000) begin n_fail++; $display("FAIL reset_arrdy got=%b exp=0000", up_arrdy); end
    n_cmp++; if ({dn_arid, dn_araddr, dn_arlen, dn_arsize, dn_arburst} !== 53'd0) begin
      n_fail++; $display("FAIL reset_fields got=%h exp=0", {dn_arid, dn_araddr, dn_arlen, dn_arsize, dn_arburst});
    end
    rst = 1'b0;
  endtask

  task automatic test_rr_order();
    do_reset();
    for (int i = 0; i < NR; i++) set_req(i, 32'h1000 + 32'(i * 16), 8'(i));
    up_arvld = 4'b1111;
    dn_arrdy = 1'b1;
    for (int k = 0; k < 6; k++) begin
      #1;
      n_cmp++; if (up_arrdy !== 4'(1 << (k % NR))) begin
        n_fail++; $display("FAIL rr_grant cyc=%0d got=%b exp=%b", k, up_arrdy, 4'(1 << (k % NR)));
      end
      if (k >= 1) begin
        n_cmp++; if ({dn_arvld, dn_arid, dn_araddr} !== {1'b1, 8'((k-1) % NR), 32'h1000 + 32'(((k-1) % NR) * 16)}) begin
          n_fail++; $display("FAIL rr_dn cyc=%0d got vld=%b id=%0d addr=%h exp id=%0d", k, dn_arvld, dn_arid, dn_araddr, (k-1) % NR);
        end
      end
      tick();
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    set_req(0, 32'h100, 8'd3);
    set_req(1, 32'h200, 8'd1);
    up_arvld = 4'b0011;
    dn_arrdy = 1'b0;
    #1;
    n_cmp++; if (up_arrdy !== 4'b0001) begin n_fail++; $display("FAIL bp_first got=%b exp=0001", up_arrdy); end
    tick();
    repeat (5) begin
      #1;
      n_cmp++; if ({dn_arvld, dn_araddr, up_arrdy} !== {1'b1, 32'h100, 4'b0000}) begin
        n_fail++; $display("FAIL bp_hold got vld=%b addr=%h arrdy=%b exp 1/100/0000", dn_arvld, dn_araddr, up_arrdy);
      end
      tick();
    end
    dn_arrdy = 1'b1;
    #1;
    n_cmp++; if (up_arrdy !== 4'b0010) begin n_fail++; $display("FAIL bp_release got=%b exp=0010", up_arrdy); end
    tick();
    up_arvld = 4'b0000;
    #1;
    n_cmp++; if ({dn_arvld, dn_arid, dn_araddr, dn_arlen} !== {1'b1, 8'd1, 32'h200, 8'd1}) begin
      n_fail++; $display("FAIL bp_next got vld=%b id=%0d addr=%h len=%0d exp 1/1/200/1", dn_arvld, dn_arid, dn_araddr, dn_arlen);
    end
  endtask

  task automatic test_outst_limit();
    do_reset();
    set_req(2, 32'h300, 8'd0);
    up_arvld = 4'b0100;
    dn_arrdy = 1'b1;
    for (int k = 0; k < MO + 2; k++) begin
      #1;
      n_cmp++; if (up_arrdy !== ((k < MO) ? 4'b0100 : 4'b0000)) begin
        n_fail++; $display("FAIL outst_grant cyc=%0d got=%b exp=%b", k, up_arrdy, (k < MO) ? 4'b0100 : 4'b0000);
      end
      tick();
    end
    dn_rvld = 1'b1; dn_rid = 8'd2; dn_rlast = 1'b1; up_rrdy = 4'b0100;
    #1;
    n_cmp++; if ({up_arrdy, up_rvld, dn_rrdy} !== {4'b0000, 4'b0100, 1'b1}) begin
      n_fail++; $display("FAIL outst_rbeat got arrdy=%b rvld=%b rrdy=%b exp 0000/0100/1", up_arrdy, up_rvld, dn_rrdy);
    end
    tick();
    dn_rvld = 1'b0;
    #1;
    n_cmp++; if (up_arrdy !== 4'b0100) begin n_fail++; $display("FAIL outst_regrant got=%b exp=0100", up_arrdy); end
    n_cmp++; if (err_stray !== 1'b0) begin n_fail++; $display("FAIL outst_err got=%b exp=0", err_stray); end
  endtask

  task automatic test_r_routing();
    logic [DW-1:0] d;
    do_reset();
    set_req(1, 32'h400, 8'd3);
    up_arvld = 4'b0010;
    dn_arrdy = 1'b1;
    tick();
    up_arvld = 4'b0000;
    tick();
    dn_rid = 8'd1;
    up_rrdy = 4'b0010;
    for (int b = 0; b < 4; b++) begin
      d = {$urandom, $urandom};
      dn_rvld = 1'b1; dn_rdata = d; dn_rresp = 2'b00; dn_rlast = (b == 3);
      if (b == 1) begin
        up_rrdy = 4'b0000;
        #1;
        n_cmp++; if ({dn_rrdy, up_rvld} !== {1'b0, 4'b0010}) begin
          n_fail++; $display("FAIL route_stall got rrdy=%b rvld=%b exp 0/0010", dn_rrdy, up_rvld);
        end
        tick();
        up_rrdy = 4'b0010;
      end
      #1;
      n_cmp++; if ({up_rvld, dn_rrdy, up_rdata, up_rlast} !== {4'b0010, 1'b1, d, (b == 3)}) begin
        n_fail++; $display("FAIL route_beat b=%0d got rvld=%b rrdy=%b data=%h last=%b", b, up_rvld, dn_rrdy, up_rdata, up_rlast);
      end
      tick();
    end
    dn_rlast = 1'b0;
    #1;
    n_cmp++; if ({up_rvld, dn_rrdy} !== {4'b0000, 1'b1}) begin
      n_fail++; $display("FAIL route_after_last got rvld=%b rrdy=%b exp 0000/1", up_rvld, dn_rrdy);
    end
    tick();
    dn_rvld = 1'b0;
  endtask

  task automatic test_stray();
    do_reset();
    set_req(2, 32'h500, 8'd0);
    up_arvld = 4'b0100;
    dn_arrdy = 1'b1;
    tick();
    up_arvld = 4'b0000;
    tick();
    dn_rvld = 1'b1; dn_rid = 8'h42; dn_rlast = 1'b1; up_rrdy = 4'b0000;
    #1;
    n_cmp++; if ({up_rvld, dn_rrdy} !== {4'b0000, 1'b1}) begin
      n_fail++; $display("FAIL stray_hibits got rvld=%b rrdy=%b exp 0000/1", up_rvld, dn_rrdy);
    end
    tick();
    dn_rid = 8'd2; up_rrdy = 4'b0100;
    #1;
    n_cmp++; if (up_rvld !== 4'b0100) begin n_fail++; $display("FAIL stray_owner_kept got=%b exp=0100", up_rvld); end
    n_cmp++; if (err_stray !== 1'b1) begin n_fail++; $display("FAIL stray_hi_err got=%b exp=1", err_stray); end
    tick();
    do_reset();
    dn_rvld = 1'b1; dn_rid = 8'd3; dn_rlast = 1'b1; up_rrdy = 4'b0000;
    #1;
    n_cmp++; if ({dn_rrdy, up_rvld, err_stray} !== {1'b1, 4'b0000, 1'b0}) begin
      n_fail++; $display("FAIL stray_beat got rrdy=%b rvld=%b err=%b exp 1/0000/0", dn_rrdy, up_rvld, err_stray);
    end
    tick();
    dn_rvld = 1'b0;
    repeat (3) begin
      #1;
      n_cmp++; if (err_stray !== 1'b1) begin n_fail++; $display("FAIL stray_sticky got=%b exp=1", err_stray); end
      tick();
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    n_cmp++; if (err_stray !== 1'b0) begin n_fail++; $display("FAIL stray_clear got=%b exp=0", err_stray); end
  endtask

  task automatic test_random();
    bit             m_hold;
    int             m_ptr;
    int             m_outst [NR];
    bit             m_err;
    logic [52:0]    m_fields;
    int             win, c, ridx;
    bit             cap, strayb;
    logic [NR-1:0]  exp_arrdy, exp_rvld;
    logic           exp_rrdy;
    do_reset();
    m_hold = 0; m_ptr = 0; m_err = 0; m_fields = '0;
    for (int i = 0; i < NR; i++) m_outst[i] = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      up_arvld = 4'($urandom);
      for (int i = 0; i < NR; i++) begin
        up_araddr[i*AW +: AW] = $urandom;
        up_arlen[i*8 +: 8]    = 8'($urandom);
        up_arsize[i*3 +: 3]   = 3'($urandom);
        up_arburst[i*2 +: 2]  = 2'($urandom);
      end
      dn_arrdy = ($urandom_range(0, 9) < 7);
      dn_rvld  = 1'($urandom_range(0, 1));
      dn_rid   = ($urandom_range(0, 9) == 0) ? 8'($urandom) : 8'($urandom_range(0, NR - 1));
      up_rrdy  = 4'($urandom);
      dn_rlast = ($urandom_range(0, 2) == 0);
      dn_rdata = {$urandom, $urandom};
      dn_rresp = 2'($urandom);
      #1;
      win = -1;
      for (int k = 0; k < NR; k++) begin
        c = (m_ptr + k) % NR;
        if (win < 0 && up_arvld[c] && m_outst[c] < MO) win = c;
      end
      cap       = (!m_hold || dn_arrdy) && (win >= 0);
      exp_arrdy = cap ? 4'(1 << win) : 4'b0000;
      ridx      = int'(dn_rid);
      strayb    = (ridx >= NR) ? 1'b1 : (m_outst[ridx] == 0);
      exp_rrdy  = strayb ? 1'b1 : up_rrdy[ridx];
      exp_rvld  = (dn_rvld && !strayb) ? 4'(1 << ridx) : 4'b0000;
      n_cmp++; if (up_arrdy !== exp_arrdy) begin n_fail++; $display("FAIL rnd_arrdy cyc=%0d got=%b exp=%b", cyc, up_arrdy, exp_arrdy); end
      n_cmp++; if (dn_arvld !== m_hold) begin n_fail++; $display("FAIL rnd_arvld cyc=%0d got=%b exp=%b", cyc, dn_arvld, m_hold); end
      n_cmp++; if ({dn_arid, dn_araddr, dn_arlen, dn_arsize, dn_arburst} !== m_fields) begin
        n_fail++; $display("FAIL rnd_fields cyc=%0d got=%h exp=%h", cyc, {dn_arid, dn_araddr, dn_arlen, dn_arsize, dn_arburst}, m_fields);
      end
      n_cmp++; if (up_rvld !== exp_rvld) begin n_fail++; $display("FAIL rnd_rvld cyc=%0d got=%b exp=%b", cyc, up_rvld, exp_rvld); end
      n_cmp++; if (dn_rrdy !== exp_rrdy) begin n_fail++; $display("FAIL rnd_rrdy cyc=%0d got=%b exp=%b", cyc, dn_rrdy, exp_rrdy); end
      n_cmp++; if ({up_rdata, up_rresp, up_rlast} !== {dn_rdata, dn_rresp, dn_rlast}) begin
        n_fail++; $display("FAIL rnd_bcast cyc=%0d got=%h exp=%h", cyc, {up_rdata, up_rresp, up_rlast}, {dn_rdata, dn_rresp, dn_rlast});
      end
      n_cmp++; if (err_stray !== m_err) begin n_fail++; $display("FAIL rnd_err cyc=%0d got=%b exp=%b", cyc, err_stray, m_err); end
      if (cap) begin
        m_hold   = 1;
        m_fields = {8'(win), up_araddr[win*AW +: AW], up_arlen[win*8 +: 8], up_arsize[win*3 +: 3], up_arburst[win*2 +: 2]};
        m_ptr    = (win + 1) % NR;
        m_outst[win]++;
      end else if (m_hold && dn_arrdy) begin
        m_hold = 0;
      end
      if (dn_rvld && !strayb && up_rrdy[ridx] && dn_rlast) m_outst[ridx]--;
      if (dn_rvld && strayb) m_err = 1;
      tick();
    end
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();
    test_reset();
    test_rr_order();
    test_backpressure();
    test_outst_limit();
    test_r_routing();
    test_stray();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/axi_rd_arb.md
# axi_rd_arb

Round-robin arbiter that shares the single AXI read interface (the LSU-side port of the AXI read block) among `NUM_REQ` load requesters, such as LSU load lanes and weight/activation prefetchers. It registers one winning AR request at a time and tags its ID with the requester index. It routes each returning R beat back to its owner by that tag and tracks per-requester outstanding bursts for flow control.

## Interface
Parameters:
- `NUM_REQ`, 4: number of requesters.
- `IDX_W`, 2: requester index width, equal to clog2(`NUM_REQ`).
- `ADDR_WIDTH`, 32: AR address width.
- `DATA_WIDTH`, 64: R data width.
- `MAX_OUTST`, 4: maximum outstanding bursts per requester (1 to 7).

Ports (per-requester fields are packed, requester i at slice i):
- `clk`, in, 1: the single clock.
- `rst`, in, 1: synchronous, active-high reset.
- `up_arvld`, in, `NUM_REQ`: requester AR valid.
- `up_araddr`, in, `NUM_REQ`*`ADDR_WIDTH`: requester AR address.
- `up_arlen`, in, `NUM_REQ`*8: requester burst length minus 1.
- `up_arsize`, in, `NUM_REQ`*3: requester beat size.
- `up_arburst`, in, `NUM_REQ`*2: requester burst type.
- `up_arrdy`, out, `NUM_REQ`: one-hot grant/accept strobe.
- `up_rvld`, out, `NUM_REQ`: routed R valid.
- `up_rdata`, out, `DATA_WIDTH`: shared R data.
- `up_rresp`, out, 2: shared R response.
- `up_rlast`, out, 1: shared R last.
- `up_rrdy`, in, `NUM_REQ`: requester R ready.
- `dn_arvld`, out, 1: downstream AR valid.
- `dn_arrdy`, in, 1: downstream AR ready.
- `dn_arid`, out, 8: downstream AR ID, equal to {zero-pad, winner index}.
- `dn_araddr`, out, `ADDR_WIDTH`: downstream AR address.
- `dn_arlen`, out, 8: downstream burst length.
- `dn_arsize`, out, 3: downstream beat size.
- `dn_arburst`, out, 2: downstream burst type.
- `dn_rvld`, in, 1: downstream R valid.
- `dn_rid`, in, 8: downstream R ID.
- `dn_rdata`, in, `DATA_WIDTH`: downstream R data.
- `dn_rresp`, in, 2: downstream R response.
- `dn_rlast`, in, 1: downstream R last.
- `dn_rrdy`, out, 1: downstream R ready.
- `err_stray`, out, 1: sticky flag for an unroutable R beat.

## Operation
- AR FSM has two states, IDLE and HOLD. A held register stores id/addr/len/size/burst.
- Eligible(i) = `up_arvld[i]` and `outst[i]` < `MAX_OUTST`.
- Capture condition: (IDLE, or HOLD with `dn_arrdy`=1) and any requester is eligible.
- On capture:
  - The round-robin winner is the first eligible requester at or after `rr_ptr`, wrapping modulo `NUM_REQ`.
  - `up_arrdy[winner]`=1 in the same cycle (combinational).
  - Winner fields load into the held register.
  - `rr_ptr` becomes winner+1, wrapping to 0 past `NUM_REQ`-1.
  - `outst[winner]` increments.
  - The FSM is in HOLD next cycle.
- In HOLD with `dn_arrdy`=1 and no eligible requester, the FSM goes to IDLE.
- `dn_arvld`=1 exactly while in HOLD. Held fields stay stable until accepted.
- R routing is combinational:
  - idx = `dn_rid[IDX_W-1:0]`.
  - `up_rvld[idx]` = `dn_rvld`, and `dn_rrdy` = `up_rrdy[idx]`.
  - data/resp/last are broadcast to all requesters.
- A beat completes when `dn_rvld`=1 and `dn_rrdy`=1. A completed beat with `dn_rlast`=1 decrements `outst[idx]`.
- Stray beat: idx ≥ `NUM_REQ`, `dn_rid[7:IDX_W]`≠0, or `outst[idx]`=0. For a stray beat:
  - `dn_rrdy`=1, so the beat is dropped.
  - No `up_rvld` is raised.
  - `err_stray` sets and stays set until reset.

## Timing
- Reset values, applied on a clocked rising edge with `rst`=1 and overriding everything:
  - FSM = IDLE, `rr_ptr`=0, all `outst`=0, held register=0, `err_stray`=0.
  - Therefore `dn_arvld`=0, all `dn_ar*` fields=0, and `up_arrdy`=0.
- A reset mid-burst discards in-flight accounting. Beats arriving after reset are flagged as stray.
- AR latency: request captured in cycle T appears as `dn_arvld` in T+1.
- Sustained throughput is one AR per cycle when `dn_arrdy` is held at 1.
- A requester that is not eligible never sees `up_arrdy`. Its `up_arvld` may stay high indefinitely.
- Same-cycle increment and decrement of `outst[i]` leaves the count unchanged.
- `outst` never exceeds `MAX_OUTST` and never underflows.
- R path latency is zero cycles, with no buffering.

## Structure
- Shared package `axi_rd_pkg`:
  - `NUM_REQ`, `IDX_W`, and the AXI ID width (8).
  - The AR FSM state enum (IDLE, HOLD).
  - The AXI resp encodings OKAY=2'b00 and SLVERR=2'b10.
- Sub-module `rr_arbiter`: `NUM_REQ`-wide, inputs eligible mask and `rr_ptr`, outputs one-hot grant and winner index. It is purely combinational; the pointer register stays in the parent.

## Test plan
- Reset check: after reset, `dn_arvld`=0, `err_stray`=0, and `up_arrdy`=0 even with `up_arvld`=4'b1111.
- Round-robin order: `up_arvld`=4'b1111 held, `dn_arrdy`=1 → grants to 0,1,2,3,0 on consecutive cycles, with `dn_arid`=0,1,2,3,0.
- Back-pressure: `dn_arrdy`=0 for 5 cycles while in HOLD with addr 0x100 → `dn_araddr` stable at 0x100, no new `up_arrdy`. Raising `dn_arrdy` gives acceptance plus the next capture in the same cycle.
- Outstanding limit: `MAX_OUTST`=4, requester 2 issues 4 bursts with no R → the 5th is blocked. One R beat with `dn_rid`=2 and `dn_rlast`=1 → the 5th is granted on the next cycle.
- R routing: `dn_rid`=1, `up_rrdy`=4'b0010, 4-beat burst → `up_rvld`=4'b0010 each beat and `outst[1]` decrements only on the last beat. With `up_rrdy[1]`=0, `dn_rrdy`=0.
- Stray beat: `dn_rid`=3 with `outst[3]`=0 → `dn_rrdy`=1, `up_rvld`=0, `err_stray`=1 from the next cycle and held until `rst`.
